// File: rtl/lap_timer_core.sv
// lap_timer_core: stopwatch / count-down timer running on the 100 Hz tick clock.
// Time is held as minutes / seconds / hundredths. Buttons are raw active-low
// inputs, synchronised and reduced to single-cycle press pulses.
// Optional feature macro: LAP_MEMORY_EN builds the lap-capture FIFO; without it
// the lap_* outputs are tied to zero and lap only acts as the seconds-adjust key.
// Output fsm_state exposes the controller state for observation.
// lap_valid semantics: high while lap_* holds an entry popped from the FIFO;
// it drops (with lap_* zeroed) when a pop finds the FIFO empty.

module lap_timer_core #(
    parameter int MAX_MINS     = 99,
    parameter int MINS_W       = 7,
    parameter int LAP_DEPTH    = 8,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic                           CLK_100Hz,
    input  logic                           reset_n,
    input  logic                           start_stop,
    input  logic                           lap,
    input  logic                           adjust,
    input  logic                           mode,
    output logic [MINS_W-1:0]              stopwatch_unit_mins,
    output logic [5:0]                     stopwatch_unit_secs,
    output logic [6:0]                     stopwatch_unit_decs,
    output logic                           stopwatch_overflow,
    output logic                           timer_expired,
    output logic [MINS_W-1:0]              lap_mins,
    output logic [5:0]                     lap_secs,
    output logic [6:0]                     lap_decs,
    output logic                           lap_valid,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           lap_lost,
    output logic [2:0]                     fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_PAUSE  = 3'd2,
        S_ADJUST = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [MINS_W-1:0] MAX_M   = MINS_W'(MAX_MINS);
    localparam logic [5:0]        SEC_MAX = 6'd59;
    localparam logic [6:0]        DEC_MAX = 7'd99;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    state_t state_q, state_d;

    // Button pipelines: [0] first sync flop, [1] second sync flop, [2] previous value.
    logic [2:0] ss_sync, lap_sync;
    // Index 0 = start_stop, index 1 = lap.
    logic [1:0] btn_press, btn_held, step;

    logic [RW-1:0] rep_cnt [2];
    logic [1:0]    rep_phase;
    logic [1:0]    rep_armed;

    logic              mode_q;
    logic              time_zero, go_adjust, start_ok, count_done;
    logic [MINS_W-1:0] up_mins, dn_mins;
    logic [5:0]        up_secs, dn_secs;
    logic [6:0]        up_decs, dn_decs;
    logic              at_max, dn_zero;

    assign fsm_state = state_q;

    // Two-flop synchronisers plus one history flop for falling-edge detection.
    always_ff @(posedge CLK_100Hz) begin
        if (!reset_n) begin
            ss_sync  <= 3'b111;
            lap_sync <= 3'b111;
        end else begin
            ss_sync  <= {ss_sync[1:0], start_stop};
            lap_sync <= {lap_sync[1:0], lap};
        end
    end

    assign btn_press[0] = ss_sync[2] & ~ss_sync[1];
    assign btn_press[1] = lap_sync[2] & ~lap_sync[1];
    assign btn_held[0]  = ~ss_sync[1];
    assign btn_held[1]  = ~lap_sync[1];

    assign time_zero = (stopwatch_unit_mins == '0) && (stopwatch_unit_secs == '0) &&
                       (stopwatch_unit_decs == '0);
    assign go_adjust = adjust && (state_q != S_ADJUST);
    // A count-down start from 00:00.00 would expire instantly, so it is refused.
    assign start_ok  = !(mode && time_zero);

    // Count-up successor with decimal carries; at_max flags the saturation point.
    always_comb begin
        up_mins = stopwatch_unit_mins;
        up_secs = stopwatch_unit_secs;
        up_decs = stopwatch_unit_decs;
        at_max  = 1'b0;
        if (stopwatch_unit_mins == MAX_M && stopwatch_unit_secs == SEC_MAX &&
            stopwatch_unit_decs == DEC_MAX) begin
            at_max = 1'b1;
        end else if (stopwatch_unit_decs == DEC_MAX) begin
            up_decs = '0;
            if (stopwatch_unit_secs == SEC_MAX) begin
                up_secs = '0;
                up_mins = stopwatch_unit_mins + MINS_W'(1);
            end else begin
                up_secs = stopwatch_unit_secs + 6'd1;
            end
        end else begin
            up_decs = stopwatch_unit_decs + 7'd1;
        end
    end

    // Count-down successor with borrows; holds at zero rather than underflowing.
    always_comb begin
        dn_mins = stopwatch_unit_mins;
        dn_secs = stopwatch_unit_secs;
        dn_decs = stopwatch_unit_decs;
        if (!time_zero) begin
            if (stopwatch_unit_decs != '0) begin
                dn_decs = stopwatch_unit_decs - 7'd1;
            end else begin
                dn_decs = DEC_MAX;
                if (stopwatch_unit_secs != '0) begin
                    dn_secs = stopwatch_unit_secs - 6'd1;
                end else begin
                    dn_secs = SEC_MAX;
                    dn_mins = stopwatch_unit_mins - MINS_W'(1);
                end
            end
        end
    end

    assign dn_zero    = (dn_mins == '0) && (dn_secs == '0) && (dn_decs == '0);
    assign count_done = mode_q ? dn_zero : at_max;

    // Controller state register.
    always_ff @(posedge CLK_100Hz) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the adjust switch overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_PAUSE: begin
                if (btn_press[0] && start_ok) state_d = S_RUN;
            end
            S_RUN: begin
                if (count_done)        state_d = S_DONE;
                else if (btn_press[0]) state_d = S_PAUSE;
            end
            S_ADJUST: begin
                if (!adjust) state_d = S_PAUSE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (go_adjust) state_d = S_ADJUST;
    end

    // Adjust steps: one on the press edge, one after REPEAT_DELAY held cycles,
    // then one every REPEAT_RATE cycles while the button stays down.
    always_comb begin
        step = '0;
        for (int b = 0; b < 2; b++) begin
            if (state_q == S_ADJUST) begin
                if (btn_press[b]) begin
                    step[b] = 1'b1;
                end else if (rep_armed[b] && btn_held[b]) begin
                    if (!rep_phase[b] && rep_cnt[b] == DELAY_LAST) step[b] = 1'b1;
                    if (rep_phase[b] && rep_cnt[b] == RATE_LAST)   step[b] = 1'b1;
                end
            end
        end
    end

    // Per-button repeat timers; armed only by an edge seen in ADJUST.
    always_ff @(posedge CLK_100Hz) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) rep_cnt[b] <= '0;
            rep_phase <= '0;
            rep_armed <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (state_q != S_ADJUST || !btn_held[b]) begin
                    rep_cnt[b]   <= '0;
                    rep_phase[b] <= 1'b0;
                    rep_armed[b] <= 1'b0;
                end else if (btn_press[b]) begin
                    rep_cnt[b]   <= '0;
                    rep_phase[b] <= 1'b0;
                    rep_armed[b] <= 1'b1;
                end else if (rep_armed[b]) begin
                    if (step[b]) begin
                        rep_cnt[b]   <= '0;
                        rep_phase[b] <= 1'b1;
                    end else begin
                        rep_cnt[b] <= rep_cnt[b] + RW'(1);
                    end
                end
            end
        end
    end

    // Time value, direction latch and sticky status flags.
    always_ff @(posedge CLK_100Hz) begin
        if (!reset_n) begin
            stopwatch_unit_mins <= '0;
            stopwatch_unit_secs <= '0;
            stopwatch_unit_decs <= '0;
            stopwatch_overflow  <= 1'b0;
            timer_expired       <= 1'b0;
            mode_q              <= 1'b0;
        end else begin
            // Direction only follows the switch while stopped.
            if (state_q == S_IDLE || state_q == S_PAUSE) mode_q <= mode;
            if (go_adjust) begin
                stopwatch_unit_decs <= '0;
                stopwatch_overflow  <= 1'b0;
                timer_expired       <= 1'b0;
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (mode_q) begin
                            stopwatch_unit_mins <= dn_mins;
                            stopwatch_unit_secs <= dn_secs;
                            stopwatch_unit_decs <= dn_decs;
                            if (dn_zero) timer_expired <= 1'b1;
                        end else if (at_max) begin
                            stopwatch_overflow <= 1'b1;
                        end else begin
                            stopwatch_unit_mins <= up_mins;
                            stopwatch_unit_secs <= up_secs;
                            stopwatch_unit_decs <= up_decs;
                        end
                    end
                    S_ADJUST: begin
                        if (step[0]) begin
                            stopwatch_unit_mins <= (stopwatch_unit_mins == MAX_M) ?
                                                   '0 : stopwatch_unit_mins + MINS_W'(1);
                        end
                        if (step[1]) begin
                            stopwatch_unit_secs <= (stopwatch_unit_secs == SEC_MAX) ?
                                                   '0 : stopwatch_unit_secs + 6'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LAP_MEMORY_EN
    localparam int PW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int CW = $clog2(LAP_DEPTH + 1);
    localparam int EW = MINS_W + 13;

    logic [EW-1:0] lap_mem [LAP_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          lap_push, lap_pop, fifo_full;
    logic [EW-1:0] rd_entry;

    assign lap_push  = (state_q == S_RUN) && btn_press[1] && !go_adjust;
    assign lap_pop   = (state_q == S_IDLE || state_q == S_PAUSE) && btn_press[1] && !go_adjust;
    assign fifo_full = (lap_count == CW'(LAP_DEPTH));
    assign rd_entry  = lap_mem[rd_ptr];

    // Lap storage; a push always lands at the write pointer, even when full.
    always_ff @(posedge CLK_100Hz) begin
        if (reset_n && lap_push) begin
            lap_mem[wr_ptr] <= {stopwatch_unit_mins, stopwatch_unit_secs, stopwatch_unit_decs};
        end
    end

    // FIFO pointers, occupancy and the popped-lap output registers.
    always_ff @(posedge CLK_100Hz) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lap_count <= '0;
            lap_lost  <= 1'b0;
            lap_mins  <= '0;
            lap_secs  <= '0;
            lap_decs  <= '0;
            lap_valid <= 1'b0;
        end else if (lap_push) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (fifo_full) begin
                // Drop the oldest entry so the newest lap is always kept.
                rd_ptr   <= rd_ptr + PW'(1);
                lap_lost <= 1'b1;
            end else begin
                lap_count <= lap_count + CW'(1);
            end
        end else if (lap_pop) begin
            if (lap_count != '0) begin
                {lap_mins, lap_secs, lap_decs} <= rd_entry;
                lap_valid <= 1'b1;
                rd_ptr    <= rd_ptr + PW'(1);
                lap_count <= lap_count - CW'(1);
            end else begin
                lap_mins  <= '0;
                lap_secs  <= '0;
                lap_decs  <= '0;
                lap_valid <= 1'b0;
            end
        end
    end
`else
    assign lap_mins  = '0;
    assign lap_secs  = '0;
    assign lap_decs  = '0;
    assign lap_valid = 1'b0;
    assign lap_count = '0;
    assign lap_lost  = 1'b0;
`endif

endmodule

// File: tb/tb_lap_timer_core.sv
// Directed bench for lap_timer_core (MAX_MINS=2, LAP_DEPTH=4, default repeat timing).
// Inputs are driven and outputs sampled on the falling clock edge.
// The lap FIFO section is compiled only when LAP_MEMORY_EN is defined.

module tb_lap_timer_core;

    localparam int MAX_MINS  = 2;
    localparam int MINS_W    = 7;
    localparam int LAP_DEPTH = 4;
    localparam int CW        = $clog2(LAP_DEPTH + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_PAUSE  = 3'd2;
    localparam logic [2:0] ST_ADJUST = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

`ifdef LAP_MEMORY_EN
    localparam int LAP_IN_RUN_COUNT = 1;
`else
    localparam int LAP_IN_RUN_COUNT = 0;
`endif

    logic              clk;
    logic              reset_n, start_stop, lap, adjust, mode;
    logic [MINS_W-1:0] sw_mins, lp_mins;
    logic [5:0]        sw_secs, lp_secs;
    logic [6:0]        sw_decs, lp_decs;
    logic              overflow, expired, lap_valid, lap_lost;
    logic [CW-1:0]     lap_count;
    logic [2:0]        fsm_state;

    int n_vec = 0;
    int n_err = 0;

    lap_timer_core #(
        .MAX_MINS(MAX_MINS), .MINS_W(MINS_W), .LAP_DEPTH(LAP_DEPTH),
        .REPEAT_DELAY(50), .REPEAT_RATE(10)
    ) dut (
        .CLK_100Hz(clk), .reset_n(reset_n), .start_stop(start_stop), .lap(lap),
        .adjust(adjust), .mode(mode),
        .stopwatch_unit_mins(sw_mins), .stopwatch_unit_secs(sw_secs),
        .stopwatch_unit_decs(sw_decs), .stopwatch_overflow(overflow),
        .timer_expired(expired), .lap_mins(lp_mins), .lap_secs(lp_secs),
        .lap_decs(lp_decs), .lap_valid(lap_valid), .lap_count(lap_count),
        .lap_lost(lap_lost), .fsm_state(fsm_state)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Time displayed as a tick count (hundredths) converted to m/s/d.
    task automatic check_ticks(input string tag, input int t);
        check({tag, ".mins"}, 32'(sw_mins), 32'(t / 6000));
        check({tag, ".secs"}, 32'(sw_secs), 32'((t / 100) % 60));
        check({tag, ".decs"}, 32'(sw_decs), 32'(t % 100));
    endtask

    task automatic check_time(input string tag, input int m, input int s, input int d);
        check_ticks(tag, m * 6000 + s * 100 + d);
    endtask

    task automatic check_all_zero(input string tag);
        check_ticks(tag, 0);
        check({tag, ".state"}, 32'(fsm_state), 32'(ST_IDLE));
        check({tag, ".ovf"}, 32'(overflow), 0);
        check({tag, ".exp"}, 32'(expired), 0);
        check({tag, ".lap_t"}, {lp_mins, lp_secs, lp_decs}, 0);
        check({tag, ".lap_valid"}, 32'(lap_valid), 0);
        check({tag, ".lap_count"}, 32'(lap_count), 0);
        check({tag, ".lap_lost"}, 32'(lap_lost), 0);
    endtask

    // One-sample press: low for a single edge N; the DUT reacts at edge N+2.
    task automatic tap(input int which);
        if (which == 0) start_stop = 1'b0;
        else            lap = 1'b0;
        @(negedge clk);
        start_stop = 1'b1;
        lap        = 1'b1;
    endtask

    // Hold so that the button reads held for t cycles after its press edge,
    // then wait until the synchroniser has fully released.
    task automatic hold(input int which, input int t);
        if (which == 0) start_stop = 1'b0;
        else            lap = 1'b0;
        cyc(t + 1);
        start_stop = 1'b1;
        lap        = 1'b1;
        cyc(3);
    endtask

`ifdef LAP_MEMORY_EN
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          now;

    task automatic check_lap(input string tag, input int t);
        check({tag, ".mins"}, 32'(lp_mins), 32'(t / 6000));
        check({tag, ".secs"}, 32'(lp_secs), 32'((t / 100) % 60));
        check({tag, ".decs"}, 32'(lp_decs), 32'(t % 100));
    endtask
`endif

    // Stimulus sequence.
    initial begin
        start_stop = 1'b1; lap = 1'b1; adjust = 1'b0; mode = 1'b0; reset_n = 1'b0;
        cyc(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        cyc(2);
        check("idle_quiet", 32'(fsm_state), 32'(ST_IDLE));

        // Count up one minute: start, 5997 cycles, then a pause press that
        // freezes the value three edges later.
        tap(0); cyc(2);
        check("run_entry.state", 32'(fsm_state), 32'(ST_RUN));
        check_ticks("run_entry", 0);
        cyc(5997);
        check_ticks("run_5997", 5997);
        tap(0); cyc(2);
        check("pause.state", 32'(fsm_state), 32'(ST_PAUSE));
        check_time("pause_1min", 1, 0, 0);
        cyc(20);
        check_time("pause_frozen", 1, 0, 0);

        // Lap press while running must not disturb the count.
        tap(0); cyc(2);
        tap(1); cyc(2);
        check_ticks("lap_in_run", 6003);
        check("lap_in_run.count", 32'(lap_count), LAP_IN_RUN_COUNT);

        reset_n = 1'b0; cyc(1);
        check_all_zero("reset_in_run");
        reset_n = 1'b1; cyc(1);

        // Count-up saturation at 02:59.99.
        tap(0); cyc(2);
        cyc(17998);
        check_time("ovf_pre2", 2, 59, 98);
        cyc(1);
        check_time("ovf_pre1", 2, 59, 99);
        check("ovf_pre1.flag", 32'(overflow), 0);
        cyc(1);
        check_time("ovf_hold", 2, 59, 99);
        check("ovf.flag", 32'(overflow), 1);
        check("ovf.state", 32'(fsm_state), 32'(ST_DONE));
        tap(0); cyc(4);
        check("done_ignores_ss", 32'(fsm_state), 32'(ST_DONE));
        check_time("done_held", 2, 59, 99);

        // Adjust out of DONE: hundredths and overflow clear, mins/secs kept.
        adjust = 1'b1; cyc(1);
        check("adj.state", 32'(fsm_state), 32'(ST_ADJUST));
        check_time("adj_entry", 2, 59, 0);
        check("adj.ovf_clr", 32'(overflow), 0);
        tap(1); cyc(2);
        check_time("secs_wrap", 2, 0, 0);
        tap(0); cyc(2);
        check_time("mins_wrap", 0, 0, 0);

        // Auto-repeat: T=100 gives 7 steps, mins wrap modulo MAX_MINS+1 -> 1.
        hold(0, 100);
        check_time("hold_ss100", 1, 0, 0);
        hold(1, 30);
        check_time("hold_lap30", 1, 1, 0);
        hold(1, 49);
        check_time("hold_lap49", 1, 2, 0);
        hold(1, 50);
        check_time("hold_lap50", 1, 4, 0);
        hold(1, 580);
        check_time("hold_lap580", 1, 59, 0);
        tap(1); cyc(2);
        check_time("secs_wrap_nocarry", 1, 0, 0);

        // Count-down from 00:01.00.
        tap(0); cyc(2);
        tap(0); cyc(2);
        tap(1); cyc(2);
        check_time("cd_set", 0, 1, 0);
        mode = 1'b1; adjust = 1'b0; cyc(1);
        check("cd_pause.state", 32'(fsm_state), 32'(ST_PAUSE));
        tap(0); cyc(2);
        check("cd_run.state", 32'(fsm_state), 32'(ST_RUN));
        check_ticks("cd_entry", 100);
        cyc(99);
        check_ticks("cd_99", 1);
        check("cd_99.exp", 32'(expired), 0);
        cyc(1);
        check_ticks("cd_zero", 0);
        check("cd_zero.exp", 32'(expired), 1);
        check("cd_zero.state", 32'(fsm_state), 32'(ST_DONE));
        tap(0); cyc(4);
        check("cd_done_hold", 32'(fsm_state), 32'(ST_DONE));

        adjust = 1'b1; cyc(1);
        check("readj.exp_clr", 32'(expired), 0);
        adjust = 1'b0; cyc(1);
        check("readj.state", 32'(fsm_state), 32'(ST_PAUSE));
        tap(0); cyc(4);
        check("start_at_zero", 32'(fsm_state), 32'(ST_PAUSE));
        check_ticks("start_at_zero", 0);

        // Mode is latched only while stopped.
        mode = 1'b0;
        tap(0); cyc(2);
        cyc(3);
        check_ticks("up_small", 3);
        mode = 1'b1; cyc(2);
        check_ticks("mode_in_run", 5);
        tap(0); cyc(2);
        check_ticks("mode_pause", 8);
        tap(0); cyc(2);
        cyc(3);
        check_ticks("mode_after_pause", 5);

`ifdef LAP_MEMORY_EN
        // Six laps into a four-deep FIFO, then five pops.
        reset_n = 1'b0; cyc(1);
        reset_n = 1'b1; mode = 1'b0; cyc(1);
        tap(0); cyc(2);
        now = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(3); now += 3;
            exp_q.push_back(32'(now + 2));
            tap(1); now += 1;
        end
        cyc(2);
        check("fifo.count", 32'(lap_count), LAP_DEPTH);
        check("fifo.lost", 32'(lap_lost), 1);
        tap(0); cyc(2);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            tap(1); cyc(2);
            e = exp_q.pop_front();
            check_lap("pop", int'(e));
            check("pop.valid", 32'(lap_valid), 1);
            check("pop.count", 32'(lap_count), 32'(3 - i));
        end
        tap(1); cyc(2);
        check("pop_empty.valid", 32'(lap_valid), 0);
        check_lap("pop_empty", 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
